// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by fetch, decode and the register file.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 8;
  localparam int OPC_W   = 4;

  localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched {pc, instruction} pairs; flush wins over push/pop.
module fetch_buffer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [1:0][W-1:0] entry_q, entry_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        entry_d[wr_ptr_q] = wdata;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      entry_q  <= entry_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = entry_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues one-cycle-latency imem reads into a 2-deep buffer with redirect.
// Define FETCH_HALT_EN to stop fetching after an OPC_HALT instruction is received.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc
);

  fetch_state_e           state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic                   inflight_q, inflight_d;
  logic                   buf_full, buf_empty;
  logic                   push, pop, issue, halt_hit;
  logic [1:0]             occupancy, occ_after;
  logic [PC_W+INSTR_W-1:0] head;

  assign pop  = !buf_empty && instr_ready;
  // Responses arriving while halted or during a redirect are dropped.
  assign push = inflight_q && !redirect && (state_q == ST_FETCH);

`ifdef FETCH_HALT_EN
  assign halt_hit = push && (opcode_of(imem_rdata) == OPC_HALT);
`else
  assign halt_hit = 1'b0;
`endif

  assign occupancy = buf_full ? 2'd2 : (buf_empty ? 2'd0 : 2'd1);
  assign occ_after = occupancy + {1'b0, push} - {1'b0, pop};

  // Only one request can be in flight, so the entry count after this cycle's
  // push/pop decides whether another response will still fit.
  assign issue = !reset && (state_q == ST_FETCH) && !redirect && !halt_hit &&
                 (occ_after < 2'd2);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = issue;
    if (redirect) begin
      state_d = ST_FETCH;
      pc_d    = redirect_pc;
    end else begin
      if (issue) pc_d = pc_q + 8'd1;
      if (halt_hit) state_d = ST_HALTED;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
    end
  end

  // The in-flight response always belongs to pc_q-1: pc only moves on issue,
  // and a redirect cancels the outstanding request.
  fetch_buffer #(
    .W(PC_W + INSTR_W)
  ) u_buffer (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({pc_q - 8'd1, imem_rdata}),
    .rdata (head),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign imem_en              = issue;
  assign imem_addr            = pc_q;
  assign instr_valid          = !buf_empty;
  assign {pc_out, instr_out}  = head;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00, meaning the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port imem_en, output, 1, instruction memory read request.
REQ-005 The block SHALL have port imem_addr, output, 8, word address of the request.
REQ-006 The block SHALL have port imem_rdata, input, 16, read data, valid exactly one cycle after imem_en=1.
REQ-007 The block SHALL have port instr_out, output, 16, instruction presented to the decoder.
REQ-008 The block SHALL have port pc_out, output, 8, address of instr_out.
REQ-009 The block SHALL have port instr_valid, output, 1, instr_out/pc_out hold a valid instruction.
REQ-010 The block SHALL have port instr_ready, input, 1, the decoder accepts the instruction this cycle.
REQ-011 The block SHALL have port redirect, input, 1, taken branch/jump request.
REQ-012 The block SHALL have port redirect_pc, input, 8, new fetch address, sampled when redirect=1.

Function
REQ-013 The block SHALL hold fetched {pc, instruction} pairs in a 2-entry FIFO buffer; instr_valid = buffer not empty; instr_out/pc_out = head entry.
REQ-014 A transfer (pop) SHALL occur when instr_valid && instr_ready; the head is held stable while instr_valid && !instr_ready.
REQ-015 The block SHALL assert imem_en in a cycle only if state is FETCH, redirect=0, and (buffer occupancy + in-flight requests) < 2; push and pop in the same cycle SHALL be accounted so that full throughput (one instruction per cycle) is sustained when instr_ready stays 1.
REQ-016 imem_addr SHALL equal PC; PC SHALL increment by 1 for each issued request, wrapping 8'hFF -> 8'h00.
REQ-017 The response SHALL be pushed into the buffer at the end of the cycle after the request, so first instr_valid appears 2 cycles after the request cycle.
REQ-018 On redirect=1: PC <= redirect_pc, buffer cleared, any in-flight response discarded, imem_en=0 that cycle; the first request to redirect_pc SHALL issue the following cycle.
REQ-019 If redirect and a pop coincide, redirect SHALL take priority; the popped instruction is considered delivered and nothing else survives.
REQ-020 The state machine SHALL have states FETCH and HALTED (HALTED reachable only per REQ-025); reset enters FETCH.
REQ-021 The buffer SHALL never overflow nor be popped when empty; pushes to a full buffer SHALL be impossible by construction of REQ-015.

Reset
REQ-022 On reset: PC=RESET_PC, buffer empty, no in-flight request, state FETCH, imem_en=0, instr_valid=0, instr_out=16'h0000, pc_out=8'h00.
REQ-023 Reset asserted mid-operation SHALL discard buffered and in-flight instructions; the first request after deassertion SHALL be to RESET_PC on the first clock edge after release.

Configuration
REQ-024 Macro FETCH_HALT_EN SHALL compile the halt feature in or out.
REQ-025 With FETCH_HALT_EN defined: a response whose bits [15:12] equal 4'hF SHALL be pushed, state goes to HALTED, no further requests issue, and later in-flight responses are discarded; redirect in HALTED returns to FETCH per REQ-018.
REQ-026 Without FETCH_HALT_EN: opcode 4'hF SHALL be fetched as an ordinary instruction, and HALTED SHALL be unreachable.

Structure
REQ-027 A shared package cpu_pkg SHALL define INSTR_W=16, PC_W=8, OPC_W=4, and OPC_HALT=4'hF; these are shared with the decoder and register file.
REQ-028 The FIFO SHALL be a sub-module fetch_buffer (2 entries, width PC_W+INSTR_W, push/pop/flush, full/empty flags).

Verification
REQ-029 Reset release, imem returns mem[a]=16'h1000+a, instr_ready=1 -> instr_valid from cycle 2 with pc_out 0,1,2,... on consecutive cycles.
REQ-030 instr_ready=0 for 5 cycles after the first valid -> head stays pc 0; imem_en stops once occupancy+in-flight=2; resume -> pc 1,2 follow with no loss or duplication.
REQ-031 redirect=1, redirect_pc=8'h40 while buffer is full and a request is in flight -> instr_valid=0 next cycle, imem_addr=8'h40 next cycle, next delivered pc_out=8'h40.
REQ-032 Starting at RESET_PC=8'hFE -> delivered pc sequence FE, FF, 00, 01.
REQ-033 With FETCH_HALT_EN defined, mem[3]=16'hF000 -> pc 0..3 delivered, no imem_en afterward; redirect to 8'h10 -> fetching resumes at 8'h10.
REQ-034 Assert reset during a stall with a full buffer -> all outputs at reset values immediately; after release the first request is to RESET_PC.
